// File: rtl/word_triple_packer_pkg.sv
// word_triple_packer_pkg: shared state encoding and default word width for the triple packer.
package word_triple_packer_pkg;
    typedef enum logic [1:0] {GET_A, GET_B, GET_C, HOLD} state_t;
    localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/word_triple_packer.sv
// word_triple_packer: packs three consecutive stream words into one registered {a, bb, bbbb} triple.
// Optional abort of a partial triple via i_flush when WORD_TRIPLE_PACKER_FLUSH_EN is defined.
module word_triple_packer
    import word_triple_packer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
    input  logic                 i_flush,
`endif
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_bb,
    output logic [WIDTH-1:0]     o_bbbb,
    output logic [CNT_WIDTH-1:0] o_count
);
    state_t state;
    logic   flush_partial;
    logic   in_xfer;
    logic   out_xfer;

`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
    assign flush_partial = i_flush && (state == GET_B || state == GET_C);
`else
    assign flush_partial = 1'b0;
`endif

    // In HOLD a new word may only enter while the held triple leaves, so no bubble appears.
    assign o_ready  = (state == HOLD) ? i_ready : !flush_partial;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= GET_A;
            o_valid <= 1'b0;
            o_a     <= '0;
            o_bb    <= '0;
            o_bbbb  <= '0;
            o_count <= '0;
        end else begin
            if (out_xfer)
                o_count <= o_count + 1'b1;
            if (flush_partial)
                state <= GET_A;
            else
                case (state)
                    GET_A: if (in_xfer) begin
                        o_a   <= i_data;
                        state <= GET_B;
                    end
                    GET_B: if (in_xfer) begin
                        o_bb  <= i_data;
                        state <= GET_C;
                    end
                    GET_C: if (in_xfer) begin
                        o_bbbb  <= i_data;
                        o_valid <= 1'b1;
                        state   <= HOLD;
                    end
                    HOLD: if (out_xfer) begin
                        o_valid <= 1'b0;
                        if (in_xfer) o_a <= i_data;
                        state <= in_xfer ? GET_B : GET_A;
                    end
                endcase
        end
    end
endmodule

// File: tb/tb_word_triple_packer.sv
// tb_word_triple_packer: directed self-checking bench; a second instance with CNT_WIDTH=2 covers counter wrap.
module tb_word_triple_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] data = '0;
    logic        o_ready, o_valid, o_ready2, o_valid2;
    logic [31:0] o_a, o_bb, o_bbbb, o_a2, o_bb2, o_bbbb2;
    logic [15:0] o_count;
    logic [1:0]  o_count2;
    int          n_cmp = 0;
    int          n_fail = 0;
`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
    logic        flush = 1'b0;
`endif

    always #5 clk = ~clk;

    word_triple_packer #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst),
`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
        .i_flush(flush),
`endif
        .i_valid(valid), .o_ready(o_ready), .i_data(data),
        .o_valid(o_valid), .i_ready(ready),
        .o_a(o_a), .o_bb(o_bb), .o_bbbb(o_bbbb), .o_count(o_count)
    );

    word_triple_packer #(.WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst(rst),
`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
        .i_flush(flush),
`endif
        .i_valid(valid), .o_ready(o_ready2), .i_data(data),
        .o_valid(o_valid2), .i_ready(ready),
        .o_a(o_a2), .o_bb(o_bb2), .o_bbbb(o_bbbb2), .o_count(o_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d want 0", o_valid); end
        n_cmp++; if (o_a !== 32'd0 || o_bb !== 32'd0 || o_bbbb !== 32'd0) begin n_fail++; $display("FAIL reset_fields got %0d,%0d,%0d want 0,0,0", o_a, o_bb, o_bbbb); end
        n_cmp++; if (o_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
        n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0d want 1", o_ready); end
    endtask

    task automatic test_basic();
        ready = 1'b1;
        valid = 1'b1;
        data = 32'd1; tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %0d want 0", o_valid); end
        data = 32'd2; tick();
        data = 32'd3; tick();
        valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0d want 1", o_valid); end
        n_cmp++; if (o_a !== 32'd1 || o_bb !== 32'd2 || o_bbbb !== 32'd3) begin n_fail++; $display("FAIL basic_fields got %0d,%0d,%0d want 1,2,3", o_a, o_bb, o_bbbb); end
        n_cmp++; if (o_count !== 16'd0) begin n_fail++; $display("FAIL basic_count_pre got %0d want 0", o_count); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %0d want 0", o_valid); end
        n_cmp++; if (o_count !== 16'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", o_count); end
        n_cmp++; if (o_bb !== 32'd2 || o_bbbb !== 32'd3) begin n_fail++; $display("FAIL basic_retain got %0d,%0d want 2,3", o_bb, o_bbbb); end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        valid = 1'b1;
        data = 32'd10; tick();
        data = 32'd11; tick();
        data = 32'd12; tick();
        data = 32'd13;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held got %0d want 0", o_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (o_valid !== 1'b1 || o_a !== 32'd10 || o_bb !== 32'd11 || o_bbbb !== 32'd12) begin n_fail++; $display("FAIL bp_hold%0d got v=%0d %0d,%0d,%0d want v=1 10,11,12", k, o_valid, o_a, o_bb, o_bbbb); end
        end
        ready = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_pass got %0d want 1", o_ready); end
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_a !== 32'd13 || o_count !== 16'd2) begin n_fail++; $display("FAIL bp_accept got v=%0d a=%0d cnt=%0d want v=0 a=13 cnt=2", o_valid, o_a, o_count); end
        data = 32'd14; tick();
        data = 32'd15; tick();
        valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_a !== 32'd13 || o_bb !== 32'd14 || o_bbbb !== 32'd15) begin n_fail++; $display("FAIL bp_next got v=%0d %0d,%0d,%0d want v=1 13,14,15", o_valid, o_a, o_bb, o_bbbb); end
        tick();
        n_cmp++; if (o_count !== 16'd3) begin n_fail++; $display("FAIL bp_count got %0d want 3", o_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            valid = 1'b1;
            data = i;
            #1;
            n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready word %0d got %0d want 1", i, o_ready); end
            tick();
            if (i % 3 == 2) begin
                n_cmp++; if (o_valid !== 1'b1 || o_a !== i - 2 || o_bb !== i - 1 || o_bbbb !== i) begin n_fail++; $display("FAIL b2b_triple word %0d got v=%0d %0d,%0d,%0d want v=1 %0d,%0d,%0d", i, o_valid, o_a, o_bb, o_bbbb, i - 2, i - 1, i); end
            end else begin
                n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap word %0d got v=%0d want 0", i, o_valid); end
            end
        end
        valid = 1'b0;
        tick();
        n_cmp++; if (o_count !== 16'd10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", o_count); end
        n_cmp++; if (o_count2 !== 2'd2) begin n_fail++; $display("FAIL b2b_count2 got %0d want 2", o_count2); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            valid = 1'b1;
            for (int w = 0; w < 3; w++) begin
                data = 100 + 3 * t + w;
                tick();
            end
            valid = 1'b0;
            tick();
            n_cmp++; if (o_count2 !== exp_w[t]) begin n_fail++; $display("FAIL wrap_count triple %0d got %0d want %0d", t, o_count2, exp_w[t]); end
        end
        n_cmp++; if (o_count !== 16'd5) begin n_fail++; $display("FAIL wrap_count16 got %0d want 5", o_count); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        valid = 1'b1;
        data = 32'd5; tick();
        data = 32'd6; tick();
        n_cmp++; if (o_a !== 32'd5 || o_bb !== 32'd6) begin n_fail++; $display("FAIL rmid_partial got %0d,%0d want 5,6", o_a, o_bb); end
        rst = 1'b1;
        data = 32'd99;
        tick();
        rst = 1'b0;
        n_cmp++; if (o_valid !== 1'b0 || o_a !== 32'd0 || o_bb !== 32'd0 || o_count !== 16'd0) begin n_fail++; $display("FAIL rmid_reset got v=%0d %0d,%0d cnt=%0d want v=0 0,0 cnt=0", o_valid, o_a, o_bb, o_count); end
        data = 32'd7; tick();
        data = 32'd8; tick();
        data = 32'd9; tick();
        valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_a !== 32'd7 || o_bb !== 32'd8 || o_bbbb !== 32'd9) begin n_fail++; $display("FAIL rmid_triple got v=%0d %0d,%0d,%0d want v=1 7,8,9", o_valid, o_a, o_bb, o_bbbb); end
        tick();
        n_cmp++; if (o_count !== 16'd1) begin n_fail++; $display("FAIL rmid_count got %0d want 1", o_count); end
    endtask

`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
    task automatic test_flush();
        do_reset();
        ready = 1'b1;
        valid = 1'b1;
        data = 32'd20; tick();
        data = 32'd21; tick();
        flush = 1'b1;
        data = 32'd77;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0d want 0", o_ready); end
        tick();
        flush = 1'b0;
        data = 32'd30; tick();
        data = 32'd31; tick();
        data = 32'd32; tick();
        valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_a !== 32'd30 || o_bb !== 32'd31 || o_bbbb !== 32'd32) begin n_fail++; $display("FAIL flush_triple got v=%0d %0d,%0d,%0d want v=1 30,31,32", o_valid, o_a, o_bb, o_bbbb); end
        tick();
        n_cmp++; if (o_count !== 16'd1) begin n_fail++; $display("FAIL flush_count got %0d want 1", o_count); end
        ready = 1'b0;
        valid = 1'b1;
        data = 32'd40; tick();
        data = 32'd41; tick();
        data = 32'd42; tick();
        valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_a !== 32'd40 || o_bbbb !== 32'd42) begin n_fail++; $display("FAIL flush_hold got v=%0d a=%0d c=%0d want v=1 a=40 c=42", o_valid, o_a, o_bbbb); end
        ready = 1'b1;
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_count !== 16'd2) begin n_fail++; $display("FAIL flush_hold_deliver got v=%0d cnt=%0d want v=0 cnt=2", o_valid, o_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef WORD_TRIPLE_PACKER_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
